// File: rtl/timer_counter_if.sv
// Bus-side signals of the timer: register window access plus the interrupt line.
// dbg_state mirrors the timer FSM so checkers can observe it.
interface timer_counter_if;
  logic [31:0] Addr;
  logic        WE;
  logic [31:0] Din;
  logic [31:0] Dout;
  logic        IRQ;
  logic [1:0]  dbg_state;

  // Handshake: no valid/ready pair. A write is taken on every rising clk edge
  // where WE=1; reads are combinational on Addr[3:2] with no request strobe.
  modport master (output Addr, WE, Din, input Dout, IRQ, dbg_state);
  modport slave  (input Addr, WE, Din, output Dout, IRQ, dbg_state);
endinterface

// File: rtl/timer_counter.sv
// Programmable down-counter timer with a 3-word register window (CTRL, PRESET, COUNT)
// raising a held (one-shot) or single-cycle (auto-reload) interrupt on expiry.
module timer_counter (
  input  logic            clk,
  input  logic            reset,
  timer_counter_if.slave  bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_CNT  = 2'd2;
  localparam logic [1:0] S_INT  = 2'd3;

  logic [1:0]  state;
  logic        enable;
  logic [1:0]  mode;
  logic        im;
  logic [31:0] preset;
  logic [31:0] count;
  logic        irq_pending;

  logic [1:0]  sel;
  logic        wr_ctrl;
  logic        wr_preset;
  logic        expire;
  logic        auto_mode;
  logic        unused_addr;

  assign sel         = bus.Addr[3:2];
  assign unused_addr = ^{bus.Addr[31:4], bus.Addr[1:0]};
  assign wr_ctrl     = bus.WE && (sel == 2'd0);
  assign wr_preset   = bus.WE && (sel == 2'd1);
  assign auto_mode   = (mode == 2'b01);
  // COUNT of 0 is treated like 1 so a zero preset still expires and never wraps.
  assign expire      = (state == S_CNT) && enable && (count <= 32'd1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      count <= 32'd0;
    end else begin
      case (state)
        S_IDLE: if (enable) state <= S_LOAD;
        S_LOAD: begin
          count <= preset;
          state <= S_CNT;
        end
        S_CNT: begin
          if (!enable) begin
            state <= S_IDLE;
          end else if (count > 32'd1) begin
            count <= count - 32'd1;
          end else begin
            count <= 32'd0;
            state <= S_INT;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // A CTRL write on the edge the one-shot INT clears Enable takes priority.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enable <= 1'b0;
      mode   <= 2'b00;
      im     <= 1'b0;
    end else if (wr_ctrl) begin
      enable <= bus.Din[0];
      mode   <= bus.Din[2:1];
      im     <= bus.Din[3];
    end else if ((state == S_INT) && !auto_mode) begin
      enable <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) preset <= 32'd0;
    else if (wr_preset) preset <= bus.Din;
  end

  // Setting wins over a same-edge bus clear so no expiry is lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) irq_pending <= 1'b0;
    else if (expire) irq_pending <= 1'b1;
    else if (wr_ctrl || wr_preset) irq_pending <= 1'b0;
    else if ((state == S_INT) && auto_mode) irq_pending <= 1'b0;
  end

  always_comb begin
    bus.Dout = 32'd0;
    case (sel)
      2'd0:    bus.Dout = {28'd0, im, mode, enable};
      2'd1:    bus.Dout = preset;
      2'd2:    bus.Dout = count;
      default: bus.Dout = 32'd0;
    endcase
  end

  assign bus.IRQ       = im & irq_pending;
  assign bus.dbg_state = state;

endmodule

// File: tb/tb_timer_counter.sv
// Self-checking bench for timer_counter: directed scenarios plus randomized runs
// compared against a closed-form timeline model of the timer.
module tb_timer_counter;

  logic clk;
  logic reset;
  timer_counter_if bus ();

  timer_counter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int passes = 0;
  logic [31:0] exp_q[$];
  logic        exp_irq_q[$];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic do_reset;
    bus.WE = 1'b0;
    bus.Din = 32'd0;
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    bus.Addr = a;
    bus.WE   = 1'b1;
    bus.Din  = d;
    @(negedge clk);
    bus.WE   = 1'b0;
    bus.Din  = 32'd0;
  endtask

  task automatic read_reg(input logic [31:0] a, output logic [31:0] d);
    bus.Addr = a;
    #1;
    d = bus.Dout;
  endtask

  // ---------------- reference model ----------------
  // State k edges after the enabling CTRL write, preset p, from a freshly reset timer.
  // Auto-reload period is max(p,1)+3: LOAD, max(p,1) counting cycles, INT, IDLE.
  function automatic void model(input int p, input bit auto_m, input bit im, input int k,
                                output int cnt, output bit irq);
    int pe;
    int ph;
    pe = (p == 0) ? 1 : p;
    if (!auto_m && k >= pe + 2) begin
      cnt = 0;
      irq = im;
    end else begin
      ph = (k - 1) % (pe + 3);
      if (ph >= 1 && ph <= pe) cnt = p - (ph - 1);
      else cnt = 0;
      irq = im && (ph == pe + 1);
    end
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset;
    logic [31:0] d;
    do_reset();
    for (int a = 0; a < 4; a++) begin
      read_reg(32'(a * 4), d);
      checks++;
      if (d !== 32'd0) $display("FAIL reset_read addr=%0h: got %h exp 0", a * 4, d);
      else passes++;
    end
    checks++;
    if (bus.IRQ !== 1'b0) $display("FAIL reset_irq: got %b exp 0", bus.IRQ);
    else passes++;
  endtask

  task automatic test_one_shot;
    logic [31:0] d;
    do_reset();
    bus_write(32'h4, 32'd3);
    bus_write(32'h0, 32'h9);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      read_reg(32'h8, d);
      if (k >= 2 && k <= 5) begin
        checks++;
        if (d !== 32'(5 - k)) $display("FAIL oneshot_count k=%0d: got %0d exp %0d", k, d, 5 - k);
        else passes++;
      end
      checks++;
      if (bus.IRQ !== (k >= 5)) $display("FAIL oneshot_irq k=%0d: got %b exp %b", k, bus.IRQ, k >= 5);
      else passes++;
      if (k >= 6) begin
        read_reg(32'h0, d);
        checks++;
        if (d !== 32'h8) $display("FAIL oneshot_ctrl k=%0d: got %h exp 8", k, d);
        else passes++;
      end
    end
    bus_write(32'h0, 32'h8);
    checks++;
    if (bus.IRQ !== 1'b0) $display("FAIL oneshot_ack: got %b exp 0", bus.IRQ);
    else passes++;
  endtask

  task automatic test_auto_reload;
    logic [31:0] d;
    logic        e;
    do_reset();
    bus_write(32'h4, 32'd3);
    bus_write(32'h0, 32'hB);
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      e = (k == 5) || (k == 11) || (k == 17);
      checks++;
      if (bus.IRQ !== e) $display("FAIL auto_irq k=%0d: got %b exp %b", k, bus.IRQ, e);
      else passes++;
      if (k == 8) begin
        read_reg(32'h8, d);
        checks++;
        if (d !== 32'd3) $display("FAIL auto_reload_count: got %0d exp 3", d);
        else passes++;
      end
    end
    bus_write(32'h0, 32'h0);
  endtask

  task automatic test_mid_count_preset;
    logic [31:0] d;
    do_reset();
    bus_write(32'h4, 32'd4);
    bus_write(32'h0, 32'hB);
    repeat (4) @(negedge clk);
    read_reg(32'h8, d);
    checks++;
    if (d !== 32'd2) $display("FAIL midpre_before: got %0d exp 2", d);
    else passes++;
    bus_write(32'h4, 32'd10);
    read_reg(32'h8, d);
    checks++;
    if (d !== 32'd1) $display("FAIL midpre_count_undisturbed: got %0d exp 1", d);
    else passes++;
    @(negedge clk);
    checks++;
    if (bus.IRQ !== 1'b1) $display("FAIL midpre_on_schedule: got %b exp 1", bus.IRQ);
    else passes++;
    repeat (3) @(negedge clk);
    read_reg(32'h8, d);
    checks++;
    if (d !== 32'd10) $display("FAIL midpre_new_period: got %0d exp 10", d);
    else passes++;
    @(negedge clk);
    read_reg(32'h8, d);
    checks++;
    if (d !== 32'd9) $display("FAIL midpre_decrement: got %0d exp 9", d);
    else passes++;
    bus_write(32'h0, 32'h0);
  endtask

  task automatic test_disable;
    logic [31:0] d;
    do_reset();
    bus_write(32'h4, 32'd9);
    bus_write(32'h0, 32'h9);
    repeat (5) @(negedge clk);
    read_reg(32'h8, d);
    checks++;
    if (d !== 32'd6) $display("FAIL disable_pre: got %0d exp 6", d);
    else passes++;
    bus_write(32'h0, 32'h8);
    for (int k = 0; k < 6; k++) begin
      read_reg(32'h8, d);
      checks++;
      if (d !== 32'd5 || bus.IRQ !== 1'b0)
        $display("FAIL disable_frozen k=%0d: got count %0d irq %b exp 5/0", k, d, bus.IRQ);
      else passes++;
      @(negedge clk);
    end
    checks++;
    if (bus.dbg_state !== 2'd0) $display("FAIL disable_idle: got state %0d exp 0", bus.dbg_state);
    else passes++;
  endtask

  task automatic test_mask;
    logic [31:0] d;
    do_reset();
    bus_write(32'h4, 32'd2);
    bus_write(32'h0, 32'h1);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      checks++;
      if (bus.IRQ !== 1'b0) $display("FAIL mask_irq k=%0d: got %b exp 0", k, bus.IRQ);
      else passes++;
    end
    bus_write(32'h4, 32'd5);
    bus_write(32'h0, 32'h8);
    checks++;
    if (bus.IRQ !== 1'b0) $display("FAIL mask_cleared_pending: got %b exp 0", bus.IRQ);
    else passes++;

    // IM written 1 on the expiry edge: pending is set on that edge and survives
    do_reset();
    bus_write(32'h4, 32'd3);
    bus_write(32'h0, 32'h1);
    repeat (4) @(negedge clk);
    bus_write(32'h0, 32'h9);
    read_reg(32'h0, d);
    checks++;
    if (bus.IRQ !== 1'b1 || d !== 32'h9)
      $display("FAIL mask_unmask_same_edge: got irq %b ctrl %h exp 1/9", bus.IRQ, d);
    else passes++;
    @(negedge clk);
    read_reg(32'h0, d);
    checks++;
    if (bus.IRQ !== 1'b1 || d !== 32'h8)
      $display("FAIL mask_unmask_hold: got irq %b ctrl %h exp 1/8", bus.IRQ, d);
    else passes++;
  endtask

  task automatic test_same_edge;
    logic [31:0] d;
    do_reset();
    bus_write(32'h4, 32'd3);
    bus_write(32'h0, 32'h9);
    repeat (4) @(negedge clk);
    bus_write(32'h4, 32'd20);
    checks++;
    if (bus.IRQ !== 1'b1) $display("FAIL same_edge_preset_irq: got %b exp 1", bus.IRQ);
    else passes++;
    @(negedge clk);
    read_reg(32'h0, d);
    checks++;
    if (bus.IRQ !== 1'b1 || d !== 32'h8)
      $display("FAIL same_edge_preset_hold: got irq %b ctrl %h exp 1/8", bus.IRQ, d);
    else passes++;

    // CTRL write on the INT edge overrides the one-shot Enable clear
    do_reset();
    bus_write(32'h4, 32'd2);
    bus_write(32'h0, 32'h9);
    repeat (4) @(negedge clk);
    checks++;
    if (bus.IRQ !== 1'b1) $display("FAIL bus_wins_expiry: got %b exp 1", bus.IRQ);
    else passes++;
    bus_write(32'h0, 32'h9);
    read_reg(32'h0, d);
    checks++;
    if (d !== 32'h9 || bus.IRQ !== 1'b0)
      $display("FAIL bus_wins_ctrl: got ctrl %h irq %b exp 9/0", d, bus.IRQ);
    else passes++;
    repeat (2) @(negedge clk);
    read_reg(32'h8, d);
    checks++;
    if (d !== 32'd2) $display("FAIL bus_wins_reload: got %0d exp 2", d);
    else passes++;
    bus_write(32'h0, 32'h0);
  endtask

  task automatic test_async_reset;
    logic [31:0] d;
    logic [31:0] c;
    do_reset();
    bus_write(32'h4, 32'd10);
    bus_write(32'h0, 32'h9);
    repeat (5) @(negedge clk);
    read_reg(32'h8, d);
    checks++;
    if (d !== 32'd7) $display("FAIL areset_pre_count: got %0d exp 7", d);
    else passes++;
    reset = 1'b1;
    read_reg(32'h8, d);
    read_reg(32'h0, c);
    checks++;
    if (d !== 32'd0 || c !== 32'd0 || bus.IRQ !== 1'b0)
      $display("FAIL areset_mid_count: got count %0d ctrl %h irq %b exp 0/0/0", d, c, bus.IRQ);
    else passes++;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    bus_write(32'h4, 32'd1);
    bus_write(32'h0, 32'h9);
    repeat (4) @(negedge clk);
    checks++;
    if (bus.IRQ !== 1'b1) $display("FAIL areset_pre_irq: got %b exp 1", bus.IRQ);
    else passes++;
    reset = 1'b1;
    read_reg(32'h4, d);
    checks++;
    if (bus.IRQ !== 1'b0 || d !== 32'd0 || bus.dbg_state !== 2'd0)
      $display("FAIL areset_irq: got irq %b preset %0d state %0d exp 0/0/0", bus.IRQ, d, bus.dbg_state);
    else passes++;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_random;
    int          p;
    int          pe;
    int          ncyc;
    int          c;
    bit          ir;
    logic [1:0]  mode;
    logic        im;
    logic        auto_m;
    logic [31:0] d;
    logic [31:0] e;
    logic        ei;
    for (int it = 0; it < 12; it++) begin
      do_reset();
      p      = int'($urandom_range(0, 9));
      mode   = 2'($urandom_range(0, 3));
      im     = 1'($urandom_range(0, 1));
      auto_m = (mode == 2'b01);
      pe     = (p == 0) ? 1 : p;
      ncyc   = 2 * (pe + 3) + 1;
      for (int k = 1; k <= ncyc; k++) begin
        model(p, auto_m, im, k, c, ir);
        exp_q.push_back(32'(c));
        exp_irq_q.push_back(ir);
      end
      bus_write(32'h4, 32'(p));
      bus_write(32'h0, {28'd0, im, mode, 1'b1});
      for (int k = 1; k <= ncyc; k++) begin
        @(negedge clk);
        read_reg(32'h8, d);
        e  = exp_q.pop_front();
        ei = exp_irq_q.pop_front();
        checks++;
        if (d !== e || bus.IRQ !== ei)
          $display("FAIL rand it=%0d p=%0d mode=%0d im=%0d k=%0d: got count %0d irq %b exp %0d/%b",
                   it, p, mode, im, k, d, bus.IRQ, e, ei);
        else passes++;
      end
      read_reg(32'h0, d);
      checks++;
      if (d !== {28'd0, im, mode, auto_m})
        $display("FAIL rand_ctrl it=%0d: got %h exp %h", it, d, {28'd0, im, mode, auto_m});
      else passes++;
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset    = 1'b1;
    bus.Addr = 32'd0;
    bus.WE   = 1'b0;
    bus.Din  = 32'd0;
    @(negedge clk);
    test_reset();
    test_one_shot();
    test_auto_reload();
    test_mid_count_preset();
    test_disable();
    test_mask();
    test_same_edge();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
